sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of one asynchronous 16-bit SRAM.
// Latency: a request seen in IDLE at cycle T acks at T+3; the next request is taken at T+4 (1 access / 4 cycles).
// Backpressure: a requester holds Req until its Ack; the loser of a tie simply waits in IDLE for the next slot.
//
// Ports:
//   Clk, Reset_n                  clock, asynchronous active-low reset
//   A_Req/A_WE/A_Addr/A_WData     port A request (CPU/ISDU datapath), sampled only in IDLE
//   A_Ack/A_RData                 port A completion pulse and held read data
//   B_*                           same as port A, for the program loader / debug port
//   ADDR, Data_to_SRAM, Data_OE   SRAM address, write data and data-bus drive enable
//   Data_from_SRAM                SRAM read data
//   Mem_CE/UB/LB/OE/WE            SRAM controls, active-low
//   Busy, Grant                   not-IDLE flag; owner of the current/last access (0 = A, 1 = B)
module sram_arbiter (
  input  logic        Clk,
  input  logic        Reset_n,

  input  logic        A_Req,
  input  logic        A_WE,
  input  logic [19:0] A_Addr,
  input  logic [15:0] A_WData,
  output logic        A_Ack,
  output logic [15:0] A_RData,

  input  logic        B_Req,
  input  logic        B_WE,
  input  logic [19:0] B_Addr,
  input  logic [15:0] B_WData,
  output logic        B_Ack,
  output logic [15:0] B_RData,

  output logic [19:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        Data_OE,
  input  logic [15:0] Data_from_SRAM,

  output logic        Mem_CE,
  output logic        Mem_UB,
  output logic        Mem_LB,
  output logic        Mem_OE,
  output logic        Mem_WE,

  output logic        Busy,
  output logic        Grant
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR1  = 3'd3,
    WR2  = 3'd4,
    ACK  = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Arbitration result for the current IDLE cycle.
  logic        any_req;
  logic        sel_b;
  logic        sel_we;

  // Access latched on leaving IDLE; requesters may change their inputs afterwards.
  logic        lat_we;
  logic [19:0] lat_addr;
  logic [15:0] lat_wdata;

  // Registered outputs.
  logic        grant_r;
  logic        a_ack_r;
  logic        b_ack_r;
  logic [15:0] a_rdata_r;
  logic [15:0] b_rdata_r;
  logic        ce_r;
  logic        oe_r;
  logic        we_r;
  logic        doe_r;
  logic        busy_r;

  // Round robin: a lone requester always wins; on a tie the port that did
  // not own the previous access wins. grant_r resets to B so A wins first.
  always_comb begin
    any_req = A_Req | B_Req;
    if (A_Req && B_Req) begin
      sel_b = ~grant_r;
    end else begin
      sel_b = B_Req;
    end
    sel_we = sel_b ? B_WE : A_WE;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = sel_we ? WR1 : RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = ACK;
      WR1:     state_nxt = WR2;
      WR2:     state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SRAM strobes are decoded from the next state so that they are plain
  // flops aligned with the state they belong to. Data_OE stays up through
  // the ACK cycle after a write as a hold cycle with Mem_WE already released;
  // it is never raised together with Mem_OE, so the bus is never contended.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      grant_r   <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= 20'd0;
      lat_wdata <= 16'd0;
      a_ack_r   <= 1'b0;
      b_ack_r   <= 1'b0;
      a_rdata_r <= 16'd0;
      b_rdata_r <= 16'd0;
      ce_r      <= 1'b1;
      oe_r      <= 1'b1;
      we_r      <= 1'b1;
      doe_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy_r  <= (state_nxt != IDLE);
      ce_r    <= (state_nxt == IDLE);
      oe_r    <= !((state_nxt == RD1) || (state_nxt == RD2));
      we_r    <= !((state_nxt == WR1) || (state_nxt == WR2));
      doe_r   <= (state_nxt == WR1) || (state_nxt == WR2) ||
                 ((state_nxt == ACK) && lat_we);
      // grant_r already names the owner by the time ACK is next.
      a_ack_r <= (state_nxt == ACK) && !grant_r;
      b_ack_r <= (state_nxt == ACK) && grant_r;

      if ((state == IDLE) && any_req) begin
        grant_r   <= sel_b;
        lat_we    <= sel_we;
        lat_addr  <= sel_b ? B_Addr  : A_Addr;
        lat_wdata <= sel_b ? B_WData : A_WData;
      end

      // Read data has had two full cycles of Mem_OE low; capture it into
      // the owner's register only, leaving the other port's data intact.
      if (state == RD2) begin
        if (grant_r) begin
          b_rdata_r <= Data_from_SRAM;
        end else begin
          a_rdata_r <= Data_from_SRAM;
        end
      end
    end
  end

  assign A_Ack        = a_ack_r;
  assign B_Ack        = b_ack_r;
  assign A_RData      = a_rdata_r;
  assign B_RData      = b_rdata_r;
  assign ADDR         = lat_addr;
  assign Data_to_SRAM = lat_wdata;
  assign Data_OE      = doe_r;
  assign Mem_CE       = ce_r;
  assign Mem_UB       = 1'b0;
  assign Mem_LB       = 1'b0;
  assign Mem_OE       = oe_r;
  assign Mem_WE       = we_r;
  assign Busy         = busy_r;
  assign Grant        = grant_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a behavioural SRAM and a transaction-level model.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: requesters follow the hold-until-Ack protocol in directed tests; the random phase toggles freely.
module tb_sram_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        A_Req, A_WE, B_Req, B_WE;
  logic [19:0] A_Addr, B_Addr;
  logic [15:0] A_WData, B_WData;
  logic        A_Ack, B_Ack;
  logic [15:0] A_RData, B_RData;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM;
  logic        Data_OE;
  logic [15:0] Data_from_SRAM;
  logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
  logic        Busy, Grant;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  sram_arbiter dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .A_Req(A_Req), .A_WE(A_WE), .A_Addr(A_Addr), .A_WData(A_WData), .A_Ack(A_Ack), .A_RData(A_RData),
    .B_Req(B_Req), .B_WE(B_WE), .B_Addr(B_Addr), .B_WData(B_WData), .B_Ack(B_Ack), .B_RData(B_RData),
    .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_OE(Data_OE), .Data_from_SRAM(Data_from_SRAM),
    .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .Busy(Busy), .Grant(Grant)
  );

  // Power-up contents of the 256-word window the bench uses (ADDR[7:0]).
  function automatic logic [15:0] init_word(input logic [7:0] i);
    if (i == 8'h23) return 16'hBEEF;
    return {i ^ 8'hA5, ~i};
  endfunction

  // Behavioural SRAM driven only by the DUT's pins.
  logic [15:0] sram    [256];
  bit          sram_wr [256];
  always @(posedge Clk) begin
    if (!Mem_CE && !Mem_WE && Data_OE) begin
      sram[ADDR[7:0]]    <= Data_to_SRAM;
      sram_wr[ADDR[7:0]] <= 1'b1;
    end
  end
  assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ?
                          (sram_wr[ADDR[7:0]] ? sram[ADDR[7:0]] : init_word(ADDR[7:0])) : 16'h0BAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one access = {owner, dir, addr, data, first busy cycle}.
  int          cyc = 0;
  bit          tx_act = 0;
  int          tx_start = 0;
  bit          tx_port, tx_we;
  logic [19:0] tx_addr;
  logic [15:0] tx_wdata;
  bit          last_grant = 1;
  logic [15:0] rd_exp [2];
  logic [15:0] ref_mem [256];
  bit          ref_wr  [256];
  int          both_low = 0;
  bit          ack_log [$];

  function automatic logic [15:0] ref_word(input logic [7:0] i);
    return ref_wr[i] ? ref_mem[i] : init_word(i);
  endfunction

  task automatic model_check();
    int off;
    bit win;
    cyc++;
    if (!Mem_OE && !Mem_WE) both_low++;
    if (A_Ack) ack_log.push_back(1'b0);
    if (B_Ack) ack_log.push_back(1'b1);
    if (!Reset_n) begin
      tx_act = 0; last_grant = 1; rd_exp[0] = 16'd0; rd_exp[1] = 16'd0;
      chk("rst_busy",  32'(Busy), 0);   chk("rst_grant", 32'(Grant), 1);
      chk("rst_addr",  32'(ADDR), 0);   chk("rst_ce",    32'(Mem_CE), 1);
      chk("rst_oe",    32'(Mem_OE), 1); chk("rst_we",    32'(Mem_WE), 1);
      chk("rst_doe",   32'(Data_OE), 0);
      chk("rst_acks",  32'({A_Ack, B_Ack}), 0);
      chk("rst_rdata", {A_RData, B_RData}, 0);
      return;
    end
    off = tx_act ? (cyc - tx_start + 1) : 0;
    if (off == 3) begin
      if (tx_we) begin
        ref_mem[tx_addr[7:0]] = tx_wdata;
        ref_wr[tx_addr[7:0]]  = 1'b1;
      end else begin
        rd_exp[tx_port] = ref_word(tx_addr[7:0]);
      end
    end
    chk("busy",    32'(Busy),    32'(tx_act));
    chk("mem_ce",  32'(Mem_CE),  32'(!tx_act));
    chk("grant",   32'(Grant),   32'(last_grant));
    chk("mem_oe",  32'(Mem_OE),  32'(!(tx_act && !tx_we && off <= 2)));
    chk("mem_we",  32'(Mem_WE),  32'(!(tx_act && tx_we && off <= 2)));
    chk("data_oe", 32'(Data_OE), 32'(tx_act && tx_we));
    chk("ub_lb",   32'({Mem_UB, Mem_LB}), 0);
    chk("a_ack",   32'(A_Ack),   32'(off == 3 && !tx_port));
    chk("b_ack",   32'(B_Ack),   32'(off == 3 && tx_port));
    chk("a_rdata", 32'(A_RData), 32'(rd_exp[0]));
    chk("b_rdata", 32'(B_RData), 32'(rd_exp[1]));
    if (tx_act) chk("addr", 32'(ADDR), 32'(tx_addr));
    if (tx_act && tx_we) chk("wdata", 32'(Data_to_SRAM), 32'(tx_wdata));
    if (off == 3) begin
      tx_act = 0;
    end else if (!tx_act && (A_Req || B_Req)) begin
      win        = (A_Req && B_Req) ? !last_grant : B_Req;
      last_grant = win;
      tx_act     = 1;
      tx_start   = cyc + 1;
      tx_port    = win;
      tx_we      = win ? B_WE    : A_WE;
      tx_addr    = win ? B_Addr  : A_Addr;
      tx_wdata   = win ? B_WData : A_WData;
    end
  endtask

  task automatic sample();
    @(negedge Clk);
    model_check();
  endtask

  task automatic drive_slot();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [19:0] addr, input logic [15:0] wdata);
    if (port) begin
      B_Req = req; B_WE = we; B_Addr = addr; B_WData = wdata;
    end else begin
      A_Req = req; A_WE = we; A_Addr = addr; A_WData = wdata;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10; i++) begin
      sample();
      drive_slot();
      if (!Busy) return;
    end
    chk("idle_timeout", 32'(Busy), 0);
  endtask

  // One access from an idle slot; inputs are scrambled right after sampling.
  task automatic do_access(input bit port, input bit we, input logic [19:0] addr, input logic [15:0] wdata,
                           output int lat, output int oe_cyc, output int we_cyc, output int doe_cyc,
                           output bit addr_held);
    lat = 0; oe_cyc = 0; we_cyc = 0; doe_cyc = 0; addr_held = 1;
    set_port(port, 1'b1, we, addr, wdata);
    sample();
    drive_slot();
    set_port(port, 1'b0, !we, addr ^ 20'h00030, ~wdata);
    for (int i = 1; i <= 8; i++) begin
      sample();
      if (!Mem_OE) oe_cyc++;
      if (!Mem_WE) we_cyc++;
      if (Data_OE) doe_cyc++;
      if (Busy && (ADDR !== addr)) addr_held = 0;
      if (port ? B_Ack : A_Ack) begin
        lat = i;
        break;
      end
      drive_slot();
    end
    drive_slot();
  endtask

  int lat, oe_c, we_c, doe_c, n_acks;
  bit held;
  logic [31:0] r;

  initial begin
    Reset_n = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 20'd0, 16'd0);
    set_port(1'b1, 1'b0, 1'b0, 20'd0, 16'd0);
    repeat (3) begin sample(); drive_slot(); end

    // Both ports requesting continuously from reset release.
    set_port(1'b0, 1'b1, 1'b0, 20'h00040, 16'h0);
    set_port(1'b1, 1'b1, 1'b0, 20'h00041, 16'h0);
    Reset_n = 1'b1;
    ack_log.delete();
    repeat (16) begin sample(); drive_slot(); end
    chk("rr_ack_count", 32'(ack_log.size()), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++)
      chk($sformatf("rr_order_%0d", i), 32'(ack_log[i]), 32'(i % 2));
    A_Req = 1'b0; B_Req = 1'b0;
    wait_idle();

    // Port A read of 0x00123 (SRAM holds 0xBEEF).
    do_access(1'b0, 1'b0, 20'h00123, 16'h0, lat, oe_c, we_c, doe_c, held);
    chk("a_rd_latency", 32'(lat), 3);
    chk("a_rd_oe_cycles", 32'(oe_c), 2);
    chk("a_rd_we_cycles", 32'(we_c), 0);
    chk("a_rd_data", 32'(A_RData), 32'h0000BEEF);
    chk("a_rd_grant", 32'(Grant), 0);

    // Port B write; neither read register may move.
    do_access(1'b1, 1'b1, 20'h0FFFF, 16'h1234, lat, oe_c, we_c, doe_c, held);
    chk("b_wr_latency", 32'(lat), 3);
    chk("b_wr_we_cycles", 32'(we_c), 2);
    chk("b_wr_doe_cycles", 32'(doe_c), 3);
    chk("b_wr_oe_cycles", 32'(oe_c), 0);
    chk("b_wr_sram", 32'(sram[8'hFF]), 32'h1234);
    chk("b_wr_a_rdata", 32'(A_RData), 32'h0000BEEF);
    chk("b_wr_b_rdata", 32'(B_RData), 32'(init_word(8'h41)));
    chk("b_wr_grant", 32'(Grant), 1);

    // Address changes to 0x00020 right after sampling 0x00010.
    do_access(1'b0, 1'b0, 20'h00010, 16'h0, lat, oe_c, we_c, doe_c, held);
    chk("addr_hold", 32'(held), 1);
    chk("addr_hold_latency", 32'(lat), 3);
    chk("addr_hold_data", 32'(A_RData), 32'(init_word(8'h10)));

    // Read back B's write through port A.
    do_access(1'b0, 1'b0, 20'h0FFFF, 16'h0, lat, oe_c, we_c, doe_c, held);
    chk("rd_after_wr", 32'(A_RData), 32'h1234);

    // Random traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      r = $urandom; A_Req = (r[1:0] != 2'b00); A_WE = r[2]; A_WData = r[31:16];
      A_Addr = {r[31:20], 4'hC, r[7:4]};
      r = $urandom; B_Req = (r[1:0] != 2'b00); B_WE = r[2]; B_WData = r[31:16];
      B_Addr = {r[31:20], 4'hC, r[7:4]};
      sample();
      drive_slot();
    end
    A_Req = 1'b0; B_Req = 1'b0;
    wait_idle();

    // Reset pulsed in WR2 of a port B write.
    set_port(1'b1, 1'b1, 1'b1, 20'h000AA, 16'h5555);
    sample(); drive_slot();
    set_port(1'b1, 1'b0, 1'b0, 20'h0, 16'h0);
    sample(); drive_slot();
    chk("pre_rst_we", 32'(Mem_WE), 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(Mem_WE), 1);
    chk("mid_rst_doe", 32'(Data_OE), 0);
    chk("mid_rst_busy", 32'(Busy), 0);
    chk("mid_rst_ce", 32'(Mem_CE), 1);
    n_acks = ack_log.size();
    sample(); drive_slot();
    Reset_n = 1'b1;
    repeat (4) begin sample(); drive_slot(); end
    chk("abort_no_ack", 32'(ack_log.size()), 32'(n_acks));
    do_access(1'b0, 1'b0, 20'h00123, 16'h0, lat, oe_c, we_c, doe_c, held);
    chk("post_rst_latency", 32'(lat), 3);
    chk("post_rst_data", 32'(A_RData), 32'h0000BEEF);
    chk("post_rst_grant", 32'(Grant), 0);

    chk("oe_we_both_low", 32'(both_low), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
